ir_scan_sched: RTL and testbench

- Sequences the IR emitter array of the line-follower sensor bar.
- The 8-bit PWM generator is shared by all emitters; this block time-multiplexes it.
- Per channel: loads that channel's duty, enables one emitter, waits a settle period, runs one ADC conversion by req/ack handshake, then posts the result.
- Sits between the control register interface, the PWM generator (duty input), the emitter drivers and the ADC front end.

---
 rtl/ir_ctrl_pkg.sv | 23 ++
 rtl/ir_duty_table.sv | 46 ++++
 rtl/ir_scan_sched.sv | 167 ++++++++++++++++
 tb/tb_ir_scan_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_ctrl_pkg.sv
// Shared state encoding, sizing constants and helpers for the IR emitter scan scheduler.
package ir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        CONVERT = 3'd3,
        NEXT    = 3'd4
    } state_t;

    localparam int IR_NUM_CH = 32'd8;
    localparam int ADC_W     = 32'd12;

    localparam logic [7:0]       DUTY_RST     = 8'h80;
    localparam logic [ADC_W-1:0] ADC_ERR_CODE = {ADC_W{1'b1}};

    // Emitter select for up to 16 channels; callers truncate to their channel count.
    function automatic logic [15:0] ch_onehot(input logic [3:0] ch);
        ch_onehot = 16'h0001 << ch;
    endfunction

endpackage

// File: rtl/ir_duty_table.sv
// Per-channel PWM duty register file: synchronous write, combinational read,
// asynchronous reset to the mid-scale default duty.
module ir_duty_table
    import ir_ctrl_pkg::*;
#(
    parameter int NUM_CH = IR_NUM_CH,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_addr,
    input  logic [7:0]      wr_data,
    input  logic [CH_W-1:0] rd_addr,
    output logic [7:0]      rd_data
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [7:0] duty_r [NUM_CH];
    logic [7:0] rd_data_s;

    // Duty storage; writes to indices beyond the channel count are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_r[i] <= DUTY_RST;
            end
        end else if (wr_en && ({1'b0, wr_addr} < NUM_CH_L)) begin
            duty_r[wr_addr] <= wr_data;
        end
    end

    // Read port; an out-of-range index returns the default duty.
    always_comb begin
        rd_data_s = DUTY_RST;
        if ({1'b0, rd_addr} < NUM_CH_L) begin
            rd_data_s = duty_r[rd_addr];
        end else begin
            rd_data_s = DUTY_RST;
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/ir_scan_sched.sv
// IR emitter scan scheduler: walks every channel, loads its duty into the shared PWM,
// lights one emitter, waits for the photodiode to settle, then runs one ADC conversion.
module ir_scan_sched #(
    parameter int NUM_CH      = 32'd8,
    parameter int SETTLE_CYC  = 32'd4096,
    parameter int ACK_TIMEOUT = 32'd1024,
    parameter int ADC_W       = 32'd12,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              duty_wr_en,
    input  logic [CH_W-1:0]   duty_wr_addr,
    input  logic [7:0]        duty_wr_data,
    output logic [7:0]        pwm_duty,
    output logic [NUM_CH-1:0] ir_en,
    output logic              adc_req,
    input  logic              adc_ack,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              res_vld,
    output logic [CH_W-1:0]   res_ch,
    output logic [ADC_W-1:0]  res_data,
    output logic              res_err,
    output logic              busy,
    output logic              scan_done
);

    import ir_ctrl_pkg::*;

    // One counter serves both the settle wait and the ack timeout, so size it for the larger.
    localparam int CNT_MAX = (SETTLE_CYC > ACK_TIMEOUT) ? SETTLE_CYC : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_CH - 1);

    state_t              state_r;
    logic [CH_W-1:0]     ch_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [7:0]          duty_rd_s;

    logic [7:0]          pwm_duty_r;
    logic [NUM_CH-1:0]   ir_en_r;
    logic                adc_req_r;
    logic                res_vld_r;
    logic [CH_W-1:0]     res_ch_r;
    logic [ADC_W-1:0]    res_data_r;
    logic                res_err_r;
    logic                busy_r;
    logic                scan_done_r;

    ir_duty_table #(
        .NUM_CH (NUM_CH)
    ) u_duty_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (duty_wr_en),
        .wr_addr (duty_wr_addr),
        .wr_data (duty_wr_data),
        .rd_addr (ch_r),
        .rd_data (duty_rd_s)
    );

    // Scan sequencer: channel walk, shared settle/timeout count and every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ch_r        <= '0;
            cnt_r       <= '0;
            pwm_duty_r  <= 8'h00;
            ir_en_r     <= '0;
            adc_req_r   <= 1'b0;
            res_vld_r   <= 1'b0;
            res_ch_r    <= '0;
            res_data_r  <= '0;
            res_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            scan_done_r <= 1'b0;
        end else begin
            res_vld_r   <= 1'b0;
            scan_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        ch_r    <= '0;
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    if (duty_rd_s == 8'h00) begin
                        res_vld_r  <= 1'b1;
                        res_ch_r   <= ch_r;
                        res_data_r <= '0;
                        res_err_r  <= 1'b0;
                        state_r    <= NEXT;
                    end else begin
                        pwm_duty_r <= duty_rd_s;
                        ir_en_r    <= NUM_CH'(ch_onehot(4'(ch_r)));
                        cnt_r      <= '0;
                        state_r    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r     <= '0;
                        adc_req_r <= 1'b1;
                        state_r   <= CONVERT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                CONVERT: begin
                    // Ack is tested first so a conversion finishing on the expiry cycle is kept.
                    if (adc_ack) begin
                        res_vld_r  <= 1'b1;
                        res_ch_r   <= ch_r;
                        res_data_r <= adc_data;
                        res_err_r  <= 1'b0;
                        adc_req_r  <= 1'b0;
                        ir_en_r    <= '0;
                        state_r    <= NEXT;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        res_vld_r  <= 1'b1;
                        res_ch_r   <= ch_r;
                        res_data_r <= {ADC_W{1'b1}};
                        res_err_r  <= 1'b1;
                        adc_req_r  <= 1'b0;
                        ir_en_r    <= '0;
                        state_r    <= NEXT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                NEXT: begin
                    if (ch_r == CH_LAST) begin
                        scan_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        ch_r    <= ch_r + CH_W'(1'b1);
                        state_r <= LOAD;
                    end
                end
                default: begin
                    ir_en_r   <= '0;
                    adc_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign pwm_duty  = pwm_duty_r;
    assign ir_en     = ir_en_r;
    assign adc_req   = adc_req_r;
    assign res_vld   = res_vld_r;
    assign res_ch    = res_ch_r;
    assign res_data  = res_data_r;
    assign res_err   = res_err_r;
    assign busy      = busy_r;
    assign scan_done = scan_done_r;

endmodule

// File: tb/tb_ir_scan_sched.sv
// Bench for ir_scan_sched: random ADC responder and duty tables checked against a scan-level model.
module tb_ir_scan_sched;

    localparam int NUM_CH      = 8;
    localparam int SETTLE_CYC  = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int ADC_W       = 12;
    localparam int ACK_DLY     = 2;
    localparam int BUDGET      = 600;

    logic              clk;
    logic              rst;
    logic              start;
    logic              duty_wr_en;
    logic [2:0]        duty_wr_addr;
    logic [7:0]        duty_wr_data;
    logic [7:0]        pwm_duty;
    logic [NUM_CH-1:0] ir_en;
    logic              adc_req;
    logic              adc_ack;
    logic [ADC_W-1:0]  adc_data;
    logic              res_vld;
    logic [2:0]        res_ch;
    logic [ADC_W-1:0]  res_data;
    logic              res_err;
    logic              busy;
    logic              scan_done;

    typedef struct {
        int               ch;
        logic [ADC_W-1:0] data;
        logic             err;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   req_rise_cyc = 0;
    res_t got_q[$];
    logic [7:0]       model_duty [NUM_CH];
    logic [7:0]       scan_duty  [NUM_CH];
    bit               noack      [NUM_CH];
    logic [ADC_W-1:0] adc_val    [NUM_CH];
    bit   mon_en = 1'b0;
    bit   spur_en = 1'b0;
    logic prev_busy, prev_req;

    ir_scan_sched #(
        .NUM_CH      (NUM_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .ADC_W       (ADC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_addr (duty_wr_addr),
        .duty_wr_data (duty_wr_data),
        .pwm_duty     (pwm_duty),
        .ir_en        (ir_en),
        .adc_req      (adc_req),
        .adc_ack      (adc_ack),
        .adc_data     (adc_data),
        .res_vld      (res_vld),
        .res_ch       (res_ch),
        .res_data     (res_data),
        .res_err      (res_err),
        .busy         (busy),
        .scan_done    (scan_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_set(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    // ADC front end: acks the ACK_DLY-th cycle of a request unless that channel is mute.
    initial begin : adc_model
        int age;
        int c;
        age = 0;
        adc_ack = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_ack = 1'b0;
            if (adc_req === 1'b1 && rst === 1'b0) begin
                age++;
                c = first_set(ir_en);
                if (age == ACK_DLY && c >= 0 && !noack[c]) begin
                    adc_data   = 12'($urandom_range(0, 4095));
                    adc_val[c] = adc_data;
                    adc_ack    = 1'b1;
                end
            end else begin
                age = 0;
                if (spur_en) begin
                    adc_ack  = 1'($urandom_range(0, 1));
                    adc_data = 12'($urandom);
                end
            end
        end
    end

    // Result collection plus per-cycle invariants of the emitter/ADC interface.
    initial begin : monitor
        int   c;
        res_t r;
        prev_busy = 1'b0;
        prev_req  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (adc_req && !prev_req) req_rise_cyc = cyc;
                if (res_vld) begin
                    r.ch = int'(res_ch);
                    r.data = res_data;
                    r.err = res_err;
                    got_q.push_back(r);
                end
                if (mon_en) begin
                    chk("ir_en_onehot", 32'($countones(ir_en) <= 1), 32'd1);
                    chk("done_on_busy_fall", 32'(scan_done), 32'(prev_busy && !busy));
                    if (adc_req) chk("req_has_emitter", 32'(ir_en != '0), 32'd1);
                    if (!busy) chk("idle_quiet", 32'({ir_en, adc_req}), 32'd0);
                    c = first_set(ir_en);
                    if (c >= 0) begin
                        chk("pwm_duty_active", 32'(pwm_duty), 32'(scan_duty[c]));
                        chk("no_skip_enable", 32'(scan_duty[c] != 8'h00), 32'd1);
                    end
                    if (res_vld) begin
                        chk("ir_en_off_at_result", 32'({ir_en, adc_req}), 32'd0);
                        if (scan_duty[res_ch] != 8'h00)
                            chk("result_latency", 32'(cyc - req_rise_cyc),
                                32'(noack[res_ch] ? ACK_TIMEOUT : ACK_DLY));
                    end
                end
            end
            prev_busy = busy;
            prev_req  = adc_req;
        end
    end

    task automatic write_duty(input int ch, input logic [7:0] val);
        @(negedge clk);
        duty_wr_en   = 1'b1;
        duty_wr_addr = 3'(ch);
        duty_wr_data = val;
        @(negedge clk);
        duty_wr_en = 1'b0;
        model_duty[ch] = val;
    endtask

    task automatic run_scan(input string tag, input int restart_at, input int wr_ch, input logic [7:0] wr_val);
        int               busy_cyc;
        int               exp_cyc;
        int               last_nz;
        bit               done_seen;
        bit               wr_done;
        logic [ADC_W-1:0] exp_data;
        logic             exp_err;
        for (int i = 0; i < NUM_CH; i++) scan_duty[i] = model_duty[i];
        got_q.delete();
        busy_cyc  = 0;
        done_seen = 1'b0;
        wr_done   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < BUDGET && !done_seen; k++) begin
            @(negedge clk);
            start      = 1'b0;
            duty_wr_en = 1'b0;
            if (busy) busy_cyc++;
            if (scan_done) done_seen = 1'b1;
            if (k == restart_at) start = 1'b1;
            if (wr_ch >= 0 && !wr_done && ir_en[wr_ch] === 1'b1) begin
                duty_wr_en   = 1'b1;
                duty_wr_addr = 3'(wr_ch);
                duty_wr_data = wr_val;
                model_duty[wr_ch] = wr_val;
                wr_done = 1'b1;
            end
        end
        start      = 1'b0;
        duty_wr_en = 1'b0;
        chk($sformatf("%s.scan_done_seen", tag), 32'(done_seen), 32'd1);
        repeat (12) @(negedge clk);
        chk($sformatf("%s.idle_after", tag), 32'(busy), 32'd0);

        exp_cyc = 0;
        last_nz = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (scan_duty[i] == 8'h00) exp_cyc += 2;
            else begin
                exp_cyc += 2 + SETTLE_CYC + (noack[i] ? ACK_TIMEOUT : ACK_DLY);
                last_nz = i;
            end
        end
        chk($sformatf("%s.busy_cycles", tag), 32'(busy_cyc), 32'(exp_cyc));
        chk($sformatf("%s.result_count", tag), 32'(got_q.size()), 32'(NUM_CH));
        for (int i = 0; i < NUM_CH && i < got_q.size(); i++) begin
            if (scan_duty[i] == 8'h00) begin
                exp_data = '0;
                exp_err  = 1'b0;
            end else if (noack[i]) begin
                exp_data = {ADC_W{1'b1}};
                exp_err  = 1'b1;
            end else begin
                exp_data = adc_val[i];
                exp_err  = 1'b0;
            end
            chk($sformatf("%s.res%0d_ch", tag, i), 32'(got_q[i].ch), 32'(i));
            chk($sformatf("%s.res%0d_data", tag, i), 32'(got_q[i].data), 32'(exp_data));
            chk($sformatf("%s.res%0d_err", tag, i), 32'(got_q[i].err), 32'(exp_err));
        end
        if (last_nz >= 0) chk($sformatf("%s.pwm_hold", tag), 32'(pwm_duty), 32'(scan_duty[last_nz]));
    endtask

    initial begin : stimulus
        int  nk;
        bit  found;
        rst = 1'b1;
        start = 1'b0;
        duty_wr_en = 1'b0;
        duty_wr_addr = 3'd0;
        duty_wr_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            model_duty[i] = 8'h80;
            scan_duty[i]  = 8'h80;
            noack[i]      = 1'b0;
            adc_val[i]    = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst.pwm_duty", 32'(pwm_duty), 32'd0);
        chk("rst.ir_en", 32'(ir_en), 32'd0);
        chk("rst.adc_req", 32'(adc_req), 32'd0);
        chk("rst.res_vld", 32'(res_vld), 32'd0);
        chk("rst.res_ch", 32'(res_ch), 32'd0);
        chk("rst.res_data", 32'(res_data), 32'd0);
        chk("rst.res_err", 32'(res_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.scan_done", 32'(scan_done), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        spur_en = 1'b1;
        repeat (2) @(negedge clk);

        // Default duties, with a second start pulse during channel 0 that must be ignored.
        run_scan("base", 5, -1, 8'h00);

        write_duty(3, 8'h40);
        write_duty(5, 8'h00);
        noack[2] = 1'b1;
        run_scan("cfg", -1, -1, 8'h00);
        noack[2] = 1'b0;

        // Rewriting the channel being measured must not change this scan, only the next.
        run_scan("actwr", -1, 6, 8'h33);
        run_scan("nextscan", -1, -1, 8'h00);

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NUM_CH; i++)
                write_duty(i, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            nk = $urandom_range(0, NUM_CH - 1);
            noack[nk] = 1'b1;
            run_scan($sformatf("rnd%0d", s), -1, -1, 8'h00);
            noack[nk] = 1'b0;
        end

        // Abort the scan with reset while channel 4 is converting.
        write_duty(4, 8'h55);
        for (int i = 0; i < NUM_CH; i++) scan_duty[i] = model_duty[i];
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < BUDGET && !found; k++) begin
            if (ir_en[4] === 1'b1 && adc_req === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid.reached_ch4_convert", 32'(found), 32'd1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.adc_req", 32'(adc_req), 32'd0);
        chk("rst_mid.ir_en", 32'(ir_en), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.res_vld", 32'(res_vld), 32'd0);
        chk("rst_mid.pwm_duty", 32'(pwm_duty), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.results_before_abort", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < got_q.size(); i++)
            chk($sformatf("rst_mid.res%0d_ch", i), 32'(got_q[i].ch), 32'(i));
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) model_duty[i] = 8'h80;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // A clean scan after reset shows the duty table back at its default everywhere.
        run_scan("post_rst", -1, -1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
